// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// alu_seq_ctrl : multiply/divide sequencer over an external add/sub/shift alu
// Option macro ALU_SEQ_EARLY_EXIT_EN stops multiply once the multiplier is 0.
// Revision: 1.0
// ============================================================================
module alu_seq_ctrl #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [1:0]   o_alu_ctrl,
  input  logic [N-1:0] i_alu_q,
  input  logic         i_alu_mayor,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [N-1:0] o_result,
  output logic [N-1:0] o_rem
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_M_TEST = 4'd1;
  localparam logic [3:0] S_M_ADD  = 4'd2;
  localparam logic [3:0] S_M_SHL  = 4'd3;
  localparam logic [3:0] S_M_SHR  = 4'd4;
  localparam logic [3:0] S_D_CMP  = 4'd5;
  localparam logic [3:0] S_D_SUB  = 4'd6;
  localparam logic [3:0] S_D_INC  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [1:0] C_ADD = 2'b00;
  localparam logic [1:0] C_SUB = 2'b10;
  localparam logic [1:0] C_SHR = 2'b01;
  localparam logic [1:0] C_SHL = 2'b11;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]  C_ONE      = N'(1);

  logic [3:0]    state_q, state_d;
  logic [N-1:0]  b_q, acc_q, mcand_q, mplier_q, rem_q, quo_q;
  logic [N-1:0]  result_q, remo_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          w_mul_last;
  logic          w_div_zero;

  assign w_div_zero = (i_b == '0);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign w_mul_last = (cnt_q == C_CNT_LAST) || (i_alu_q == '0);
`else
  assign w_mul_last = (cnt_q == C_CNT_LAST);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (!i_op)          state_d = S_M_TEST;
          else if (w_div_zero) state_d = S_DONE;
          else                state_d = S_D_CMP;
        end
      end
      S_M_TEST: state_d = mplier_q[0] ? S_M_ADD : S_M_SHL;
      S_M_ADD:  state_d = S_M_SHL;
      S_M_SHL:  state_d = S_M_SHR;
      S_M_SHR:  state_d = w_mul_last ? S_DONE : S_M_TEST;
      S_D_CMP:  state_d = i_alu_mayor ? S_DONE : S_D_SUB;
      S_D_SUB:  state_d = S_D_INC;
      S_D_INC:  state_d = S_D_CMP;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = C_ADD;
    case (state_q)
      S_M_ADD: begin o_alu_a = acc_q;    o_alu_b = mcand_q; o_alu_ctrl = C_ADD; end
      S_M_SHL: begin o_alu_a = mcand_q;  o_alu_ctrl = C_SHL; end
      S_M_SHR: begin o_alu_a = mplier_q; o_alu_ctrl = C_SHR; end
      S_D_CMP: begin o_alu_a = b_q;      o_alu_b = rem_q;   o_alu_ctrl = C_ADD; end
      S_D_SUB: begin o_alu_a = rem_q;    o_alu_b = b_q;     o_alu_ctrl = C_SUB; end
      S_D_INC: begin o_alu_a = quo_q;    o_alu_b = C_ONE;   o_alu_ctrl = C_ADD; end
      default: ;
    endcase
  end

  // Datapath registers; results are captured on the edge that enters DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      remo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            b_q      <= i_b;
            acc_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= i_a;
            mplier_q <= i_b;
            rem_q    <= i_a;
            result_q <= '0;
            if (i_op && w_div_zero) begin
              err_q  <= 1'b1;
              remo_q <= i_a;
            end else begin
              err_q  <= 1'b0;
              remo_q <= '0;
            end
          end
        end
        S_M_ADD: acc_q <= i_alu_q;
        S_M_SHL: mcand_q <= i_alu_q;
        S_M_SHR: begin
          mplier_q <= i_alu_q;
          cnt_q    <= cnt_q + CW'(1);
          if (w_mul_last) begin
            result_q <= acc_q;
            remo_q   <= '0;
          end
        end
        S_D_CMP: begin
          if (i_alu_mayor) begin
            result_q <= quo_q;
            remo_q   <= rem_q;
          end
        end
        S_D_SUB: rem_q <= i_alu_q;
        S_D_INC: quo_q <= i_alu_q;
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_err    = err_q;
  assign o_result = result_q;
  assign o_rem    = remo_q;

endmodule
`default_nettype wire
